otter_mcu_fsm: RTL and testbench
================================

Name: otter_mcu_fsm

Overview:
Multicycle sequencer for the OTTER RV32I datapath. It steps each instruction through fetch, execute and optional memory-wait states, handshaking with instruction and data memory. It drives the PC, register-file, memory and CSR write strobes, and takes interrupts between instructions. It sits beside the combinational decoder, which supplies ALU and mux selects; this block supplies all timing.

Parameters:
TIMEOUT_CYCLES, 16, max cycles to wait for a memory ack before bus error (>=2)
INTR_SYNC_STAGES, 2, flop stages synchronizing CU_INTR (>=1)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
CU_OPCODE  in  7  instruction opcode, stable from FETCH ack through instruction end
CU_FUNC3  in  3  instruction func3
CU_BR_EQ / CU_BR_LT / CU_BR_LTU  in  1 each  branch comparator flags
CU_INTR  in  1  external interrupt request, asynchronous level
CU_MIE  in  1  mstatus.MIE interrupt enable
IMEM_ACK  in  1  instruction read complete
DMEM_ACK  in  1  data read/write complete
CU_PC_WRITE  out  1  PC register load
CU_PC_SOURCE  out  3  PC mux select: 0 PC+4, 1 JALR, 2 branch, 3 JAL, 4 mtvec, 5 mepc
CU_REG_WRITE  out  1  register file write enable
CU_MEM_RDEN1  out  1  instruction read request
CU_MEM_RDEN2  out  1  data read request
CU_MEM_WE2  out  1  data write request
CU_CSR_WE  out  1  CSR write enable
CU_INT_TAKEN  out  1  interrupt entry pulse (CSR saves mepc, clears MIE)
CU_BUS_ERR  out  1  sticky memory-timeout flag
CU_STATE  out  3  current state, debug: 0 FETCH, 1 EXEC, 2 MEM_WAIT, 3 INTR, 4 HALT

Behaviour:
- Reset (RST_N low, asynchronous): state FETCH, wait counter 0, store flag 0, CU_BUS_ERR 0, sync flops 0. While RST_N is low, all outputs are forced 0.
- Outputs are combinational from state and, in EXEC, from opcode. Any output not listed for a state is 0.
- intr_pending = last sync stage of CU_INTR AND CU_MIE.
- "Retire" means: go to INTR if intr_pending, else go to FETCH.
- FETCH:
  - CU_MEM_RDEN1=1, held until IMEM_ACK.
  - IMEM_ACK -> EXEC.
- EXEC, one cycle, by opcode:
  - LOAD: CU_MEM_RDEN2=1; latch store flag=0; -> MEM_WAIT.
  - STORE: CU_MEM_WE2=1; latch store flag=1; -> MEM_WAIT.
  - BRANCH: PC_WRITE=1. PC_SOURCE=2 if the condition holds, else 0. Conditions by func3: 000 EQ, 001 !EQ, 100 LT, 101 !LT, 110 LTU, 111 !LTU; 010/011 are false. Retire.
  - JAL: PC_WRITE=1, REG_WRITE=1, PC_SOURCE=3. Retire.
  - JALR: PC_WRITE=1, REG_WRITE=1, PC_SOURCE=1. Retire.
  - LUI/AUIPC/OP/OP_IMM: PC_WRITE=1, REG_WRITE=1, PC_SOURCE=0. Retire.
  - SYSTEM func3=000 (mret): PC_WRITE=1, PC_SOURCE=5. Retire.
  - SYSTEM func3=001/010/011/101/110/111: PC_WRITE=1, REG_WRITE=1, CSR_WE=1, PC_SOURCE=0. Retire.
  - SYSTEM func3=100 and undefined opcodes: treated as NOP, PC_WRITE=1, PC_SOURCE=0. Retire.
- MEM_WAIT:
  - Hold RDEN2 (store flag 0) or WE2 (store flag 1) until DMEM_ACK.
  - In the ack cycle: PC_WRITE=1, PC_SOURCE=0, and REG_WRITE=1 for a load. Retire.
  - A DMEM_ACK in the EXEC cycle is ignored; only acks seen in MEM_WAIT count.
- INTR, one cycle: PC_WRITE=1, PC_SOURCE=4, CU_INT_TAKEN=1; -> FETCH. Interrupts are never taken mid-instruction.
- Timeout:
  - The wait counter clears on every state change and increments each cycle in FETCH or MEM_WAIT without the ack.
  - If the counter reaches TIMEOUT_CYCLES-1 and the ack is still absent that cycle: CU_BUS_ERR<=1, -> HALT.
  - An ack arriving in that same cycle wins; no error is raised.
- HALT: all strobes 0, CU_BUS_ERR stays 1. Only reset exits.
- Reset asserted mid-instruction aborts immediately; no partial writes complete after deassertion.
- Interrupt latency: CU_INTR must be high for INTR_SYNC_STAGES cycles before retirement to be taken at that retirement.

Test Plan:
- ADDI, opcode 0010011, IMEM_ACK on first FETCH cycle -> FETCH, EXEC, FETCH; PC_WRITE=1, REG_WRITE=1, PC_SOURCE=0 in the EXEC cycle only.
- BEQ with EQ=1, then BGEU with LTU=1 -> PC_SOURCE=2 for BEQ, PC_SOURCE=0 for BGEU; REG_WRITE=0 for both.
- LW, DMEM_ACK after 3 MEM_WAIT cycles -> RDEN2 high for 4 cycles (EXEC + 3 wait); REG_WRITE=1 in the ack cycle only.
- SW, DMEM_ACK after 1 cycle -> WE2 high for 2 cycles, REG_WRITE=0.
- CU_INTR=1, MIE=1 held 2 cycles before an ADD retires -> INTR state, PC_SOURCE=4, INT_TAKEN=1 for one cycle, then FETCH.
- Same interrupt with MIE=0 -> no INTR state.
- IMEM_ACK never arrives, TIMEOUT_CYCLES=16 -> BUS_ERR=1 after 16 FETCH cycles, CU_STATE=4.
- RST_N low mid-MEM_WAIT -> all outputs 0 immediately; FETCH after release.

Source files
------------

// File: rtl/otter_mcu_fsm_if.sv
// Control bus between the OTTER multicycle sequencer and the datapath/memories.
// The master side is the sequencer; the slave side is the datapath and memory.
interface otter_mcu_fsm_if;
  logic [6:0] CU_OPCODE;
  logic [2:0] CU_FUNC3;
  logic       CU_BR_EQ;
  logic       CU_BR_LT;
  logic       CU_BR_LTU;
  logic       CU_INTR;
  logic       CU_MIE;
  logic       IMEM_ACK;
  logic       DMEM_ACK;
  logic       CU_PC_WRITE;
  logic [2:0] CU_PC_SOURCE;
  logic       CU_REG_WRITE;
  logic       CU_MEM_RDEN1;
  logic       CU_MEM_RDEN2;
  logic       CU_MEM_WE2;
  logic       CU_CSR_WE;
  logic       CU_INT_TAKEN;
  logic       CU_BUS_ERR;
  logic [2:0] CU_STATE;

  modport master (
    input  CU_OPCODE, CU_FUNC3, CU_BR_EQ, CU_BR_LT, CU_BR_LTU,
    input  CU_INTR, CU_MIE, IMEM_ACK, DMEM_ACK,
    output CU_PC_WRITE, CU_PC_SOURCE, CU_REG_WRITE, CU_MEM_RDEN1,
    output CU_MEM_RDEN2, CU_MEM_WE2, CU_CSR_WE, CU_INT_TAKEN,
    output CU_BUS_ERR, CU_STATE
  );

  modport slave (
    output CU_OPCODE, CU_FUNC3, CU_BR_EQ, CU_BR_LT, CU_BR_LTU,
    output CU_INTR, CU_MIE, IMEM_ACK, DMEM_ACK,
    input  CU_PC_WRITE, CU_PC_SOURCE, CU_REG_WRITE, CU_MEM_RDEN1,
    input  CU_MEM_RDEN2, CU_MEM_WE2, CU_CSR_WE, CU_INT_TAKEN,
    input  CU_BUS_ERR, CU_STATE
  );
endinterface

// File: rtl/otter_mcu_fsm.sv
// OTTER RV32I multicycle sequencer: fetch / execute / memory-wait stepping,
// interrupt entry between instructions and memory-ack timeout to a HALT state.
module otter_mcu_fsm #(
  parameter int TIMEOUT_CYCLES   = 16,
  parameter int INTR_SYNC_STAGES = 2
) (
  input logic            CLK,
  input logic            RST_N,
  otter_mcu_fsm_if.master bus
);

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_EXEC  = 3'd1;
  localparam logic [2:0] ST_MWAIT = 3'd2;
  localparam logic [2:0] ST_INTR  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] PCS_PC4   = 3'd0;
  localparam logic [2:0] PCS_JALR  = 3'd1;
  localparam logic [2:0] PCS_BR    = 3'd2;
  localparam logic [2:0] PCS_JAL   = 3'd3;
  localparam logic [2:0] PCS_MTVEC = 3'd4;
  localparam logic [2:0] PCS_MEPC  = 3'd5;

  localparam int          CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [2:0]                  state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        store_q, store_d;
  logic                        bus_err_q, bus_err_d;
  logic [INTR_SYNC_STAGES-1:0] sync_q, sync_d;
  logic [INTR_SYNC_STAGES:0]   sync_shift_s;

  logic       pc_write_s, reg_write_s, rden1_s, rden2_s, we2_s, csr_we_s, int_taken_s;
  logic [2:0] pc_source_s;
  logic       intr_pending_s;

  function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                        input logic lt, input logic ltu);
    logic taken;
    case (f3)
      3'b000:  taken = eq;
      3'b001:  taken = ~eq;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  assign sync_shift_s   = {sync_q, bus.CU_INTR};
  assign intr_pending_s = sync_q[INTR_SYNC_STAGES-1] & bus.CU_MIE;

  // Next-state, strobe and timeout logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    bus_err_d   = bus_err_q;
    sync_d      = sync_shift_s[INTR_SYNC_STAGES-1:0];
    pc_write_s  = 1'b0;
    pc_source_s = PCS_PC4;
    reg_write_s = 1'b0;
    rden1_s     = 1'b0;
    rden2_s     = 1'b0;
    we2_s       = 1'b0;
    csr_we_s    = 1'b0;
    int_taken_s = 1'b0;

    case (state_q)
      ST_FETCH: begin
        rden1_s = 1'b1;
        if (bus.IMEM_ACK) begin
          state_d = ST_EXEC;
        end else if (cnt_q == TMO_LAST) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_EXEC: begin
        state_d = intr_pending_s ? ST_INTR : ST_FETCH;
        case (bus.CU_OPCODE)
          OP_LOAD: begin
            rden2_s = 1'b1;
            store_d = 1'b0;
            state_d = ST_MWAIT;
          end
          OP_STORE: begin
            we2_s   = 1'b1;
            store_d = 1'b1;
            state_d = ST_MWAIT;
          end
          OP_BRANCH: begin
            pc_write_s  = 1'b1;
            pc_source_s = branch_taken(bus.CU_FUNC3, bus.CU_BR_EQ, bus.CU_BR_LT,
                                       bus.CU_BR_LTU) ? PCS_BR : PCS_PC4;
          end
          OP_JAL: begin
            pc_write_s  = 1'b1;
            reg_write_s = 1'b1;
            pc_source_s = PCS_JAL;
          end
          OP_JALR: begin
            pc_write_s  = 1'b1;
            reg_write_s = 1'b1;
            pc_source_s = PCS_JALR;
          end
          OP_LUI, OP_AUIPC, OP_OP, OP_OPIMM: begin
            pc_write_s  = 1'b1;
            reg_write_s = 1'b1;
          end
          OP_SYSTEM: begin
            pc_write_s = 1'b1;
            if (bus.CU_FUNC3 == 3'b000) begin
              pc_source_s = PCS_MEPC;
            end else if (bus.CU_FUNC3 != 3'b100) begin
              reg_write_s = 1'b1;
              csr_we_s    = 1'b1;
            end else begin
              pc_source_s = PCS_PC4;
            end
          end
          // Undefined opcodes retire as a NOP.
          default: begin
            pc_write_s = 1'b1;
          end
        endcase
      end
      ST_MWAIT: begin
        rden2_s = ~store_q;
        we2_s   = store_q;
        if (bus.DMEM_ACK) begin
          pc_write_s  = 1'b1;
          reg_write_s = ~store_q;
          state_d     = intr_pending_s ? ST_INTR : ST_FETCH;
        end else if (cnt_q == TMO_LAST) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_INTR: begin
        pc_write_s  = 1'b1;
        pc_source_s = PCS_MTVEC;
        int_taken_s = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_d;
    end
  end

  // State, wait counter, store flag, sticky error and interrupt synchronizer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_FETCH;
      cnt_q     <= '0;
      store_q   <= 1'b0;
      bus_err_q <= 1'b0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      store_q   <= store_d;
      bus_err_q <= bus_err_d;
      sync_q    <= sync_d;
    end
  end

  // Strobes are forced low the instant reset asserts, independent of state.
  assign bus.CU_PC_WRITE  = RST_N & pc_write_s;
  assign bus.CU_PC_SOURCE = {3{RST_N}} & pc_source_s;
  assign bus.CU_REG_WRITE = RST_N & reg_write_s;
  assign bus.CU_MEM_RDEN1 = RST_N & rden1_s;
  assign bus.CU_MEM_RDEN2 = RST_N & rden2_s;
  assign bus.CU_MEM_WE2   = RST_N & we2_s;
  assign bus.CU_CSR_WE    = RST_N & csr_we_s;
  assign bus.CU_INT_TAKEN = RST_N & int_taken_s;
  assign bus.CU_BUS_ERR   = RST_N & bus_err_q;
  assign bus.CU_STATE     = {3{RST_N}} & state_q;

endmodule

// File: tb/tb_otter_mcu_fsm.sv
// Directed bench for otter_mcu_fsm: expected strobe vectors are queued as each
// cycle's stimulus is applied and compared against the DUT mid-cycle.
module tb_otter_mcu_fsm;
  logic clk;
  logic rst_n;
  otter_mcu_fsm_if bus ();

  otter_mcu_fsm #(.TIMEOUT_CYCLES(16), .INTR_SYNC_STAGES(2)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [13:0] exp_q[$];
  string       tag_q[$];
  int          compared;
  int          mismatched;

  // {pc_write, pc_source, reg_write, rden1, rden2, we2, csr_we, int_taken, bus_err, state}
  function automatic logic [13:0] ev(input logic pcw, input logic [2:0] pcs,
                                     input logic rw, input logic r1, input logic r2,
                                     input logic we, input logic csr, input logic it,
                                     input logic be, input logic [2:0] st);
    return {pcw, pcs, rw, r1, r2, we, csr, it, be, st};
  endfunction

  function automatic logic [13:0] observed();
    return {bus.CU_PC_WRITE, bus.CU_PC_SOURCE, bus.CU_REG_WRITE, bus.CU_MEM_RDEN1,
            bus.CU_MEM_RDEN2, bus.CU_MEM_WE2, bus.CU_CSR_WE, bus.CU_INT_TAKEN,
            bus.CU_BUS_ERR, bus.CU_STATE};
  endfunction

  task automatic expect_out(input string tag, input logic [13:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic compare_pop();
    logic [13:0] e;
    logic [13:0] o;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = observed();
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", t, o, e);
    end
  endtask

  // One clock cycle: inputs already applied, queue expectation, check at negedge.
  task automatic step(input string tag, input logic [13:0] exp);
    expect_out(tag, exp);
    @(negedge clk);
    compare_pop();
    @(posedge clk);
    #1;
  endtask

  logic [13:0] e_fetch;
  logic [13:0] e_alu;

  initial begin
    compared   = 0;
    mismatched = 0;
    e_fetch = ev(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    e_alu   = ev(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    rst_n = 1'b0;
    bus.CU_OPCODE = OP_OPIMM; bus.CU_FUNC3 = 3'b000;
    bus.CU_BR_EQ = 1'b0; bus.CU_BR_LT = 1'b0; bus.CU_BR_LTU = 1'b0;
    bus.CU_INTR = 1'b0; bus.CU_MIE = 1'b0;
    bus.IMEM_ACK = 1'b0; bus.DMEM_ACK = 1'b0;

    #3;
    expect_out("reset_zero", 14'd0);
    compare_pop();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADDI
    bus.IMEM_ACK = 1'b1;                         step("addi_fetch", e_fetch);
    bus.IMEM_ACK = 1'b0;                         step("addi_exec", e_alu);
    // BEQ taken
    bus.CU_OPCODE = OP_BRANCH; bus.CU_FUNC3 = 3'b000; bus.CU_BR_EQ = 1'b1;
    bus.IMEM_ACK = 1'b1;                         step("beq_fetch", e_fetch);
    bus.IMEM_ACK = 1'b0;
    step("beq_exec", ev(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    // BGEU with LTU=1 not taken
    bus.CU_FUNC3 = 3'b111; bus.CU_BR_EQ = 1'b0; bus.CU_BR_LTU = 1'b1;
    bus.IMEM_ACK = 1'b1;                         step("bgeu_fetch", e_fetch);
    bus.IMEM_ACK = 1'b0;
    step("bgeu_exec", ev(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    bus.CU_BR_LTU = 1'b0;
    // LW, ack in EXEC ignored, ack after 3 wait cycles
    bus.CU_OPCODE = OP_LOAD; bus.CU_FUNC3 = 3'b010;
    bus.IMEM_ACK = 1'b1;                         step("lw_fetch", e_fetch);
    bus.IMEM_ACK = 1'b0; bus.DMEM_ACK = 1'b1;
    step("lw_exec", ev(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    bus.DMEM_ACK = 1'b0;
    step("lw_wait1", ev(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2));
    step("lw_wait2", ev(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2));
    bus.DMEM_ACK = 1'b1;
    step("lw_ack", ev(1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2));
    bus.DMEM_ACK = 1'b0;
    // SW, ack after 1 cycle; interrupt rises during the ack cycle
    bus.CU_OPCODE = OP_STORE;
    bus.IMEM_ACK = 1'b1;                         step("sw_fetch", e_fetch);
    bus.IMEM_ACK = 1'b0;
    step("sw_exec", ev(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1));
    bus.DMEM_ACK = 1'b1; bus.CU_INTR = 1'b1; bus.CU_MIE = 1'b1;
    step("sw_ack", ev(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2));
    bus.DMEM_ACK = 1'b0;
    // ADD retires with a synchronized pending interrupt
    bus.CU_OPCODE = OP_OP;
    bus.IMEM_ACK = 1'b1;                         step("add_fetch", e_fetch);
    bus.IMEM_ACK = 1'b0;                         step("add_exec", e_alu);
    bus.CU_INTR = 1'b0;
    step("intr_entry", ev(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3));
    // Same interrupt masked by MIE=0
    bus.CU_INTR = 1'b1; bus.CU_MIE = 1'b0;
    step("masked_stall", e_fetch);
    bus.IMEM_ACK = 1'b1;                         step("masked_fetch", e_fetch);
    bus.IMEM_ACK = 1'b0;                         step("masked_exec", e_alu);
    bus.CU_INTR = 1'b0;
    // JAL, CSRRW, MRET
    bus.CU_OPCODE = OP_JAL;
    bus.IMEM_ACK = 1'b1;                         step("jal_fetch", e_fetch);
    bus.IMEM_ACK = 1'b0;
    step("jal_exec", ev(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    bus.CU_OPCODE = OP_SYSTEM; bus.CU_FUNC3 = 3'b001;
    bus.IMEM_ACK = 1'b1;                         step("csr_fetch", e_fetch);
    bus.IMEM_ACK = 1'b0;
    step("csr_exec", ev(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1));
    bus.CU_FUNC3 = 3'b000;
    bus.IMEM_ACK = 1'b1;                         step("mret_fetch", e_fetch);
    bus.IMEM_ACK = 1'b0;
    step("mret_exec", ev(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    // Reset asserted mid MEM_WAIT
    bus.CU_OPCODE = OP_LOAD;
    bus.IMEM_ACK = 1'b1;                         step("lw2_fetch", e_fetch);
    bus.IMEM_ACK = 1'b0;
    step("lw2_exec", ev(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    step("lw2_wait", ev(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2));
    rst_n = 1'b0;
    #1;
    expect_out("reset_mid_wait", 14'd0);
    compare_pop();
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Ack arriving on the last allowed cycle wins over the timeout
    bus.CU_OPCODE = OP_OPIMM;
    for (int i = 0; i < 15; i++) step("fetch_after_reset", e_fetch);
    bus.IMEM_ACK = 1'b1;                         step("fetch_last_ack", e_fetch);
    bus.IMEM_ACK = 1'b0;                         step("ack_wins_exec", e_alu);
    // IMEM_ACK never arrives
    for (int i = 0; i < 16; i++) step("timeout_fetch", e_fetch);
    step("halt", ev(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4));
    bus.IMEM_ACK = 1'b1;
    step("halt_sticky", ev(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
